dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder for the pipeline's data port: accepts the load/store request driven from the execute stage (address, write data, read/write strobes), models a fixed-latency word-addressed data RAM, and returns read data. It drives the `busy` signal the pipeline uses to hold its EX/MEM register, so one request completes per handshake and the pipeline stalls for exactly the configured latency.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, 16..65536.
- `LATENCY`, 2: extra wait cycles per access; 0..15.
- `AW`, $clog2(DEPTH_WORDS): derived word-index width; not overridden.

- `i_clk`  in  1  single clock; all logic on rising edge.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_ren`  in  1  read request.
- `i_wen`  in  1  write request.
- `i_addr`  in  32  byte address; word index = `i_addr[AW+1:2]`.
- `i_wdata`  in  32  store data.
- `i_mask`  in  4  byte enables for stores; bit n writes byte n (`[8n+7:8n]`).
- `o_busy`  out  1  request not yet complete; requester holds its stage and request.
- `o_rdata`  out  32  load data, registered.
- `o_rvld`  out  1  one-cycle pulse: `o_rdata` holds new load data.
- `o_err`  out  1  one-cycle pulse: `i_ren` and `i_wen` were both high at acceptance.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: request = `i_ren | i_wen`. On request, latch addr/wdata/mask/op; go WAIT with `cnt = LATENCY-1`, or RESP directly if `LATENCY == 0`.
- WAIT: decrement `cnt`; at `cnt == 0` go RESP. Request inputs ignored; only latched copies are used.
- Completing edge (the one that enters RESP): stores write RAM bytes selected by latched mask (mask 0 writes nothing); loads register the full word into `o_rdata` and set `o_rvld` for the RESP cycle.
- RESP: `o_busy` low; the requester advances at this edge. The request still present in RESP is not re-accepted. Always return to IDLE.
- `o_busy = (IDLE & request) | WAIT`; combinational from the request in IDLE so the first cycle stalls. Forced 0 while `i_rst_n` is low.
- Both `i_ren` and `i_wen` high: treated as a write. `o_err` pulses during RESP.
- `i_addr[1:0]` are ignored (no misalignment trap). `i_addr[31:AW+2]` are ignored, so addresses wrap modulo `DEPTH_WORDS`.
- `o_rdata` holds its value until the next load completes. Stores do not change it.

## Timing
- Reset values: state IDLE, `cnt` 0, `o_busy` 0, `o_rdata` 0, `o_rvld` 0, `o_err` 0. RAM contents are not reset.
- A request first seen in cycle 0 gives `o_busy` high for cycles 0..LATENCY (LATENCY+1 cycles). RESP is cycle LATENCY+1.
- Back-to-back requests: a new request can be accepted in the cycle after RESP. Issue interval is LATENCY+2 cycles.
- Reset mid-access, in WAIT or on the completing edge: go to IDLE. The pending store is not performed, `o_rdata` clears to 0, and no `o_rvld`/`o_err` pulse is produced.
- Read-after-write to the same word in consecutive requests returns the new data; the RAM write completes before the next acceptance.

## Structure
- Package `dmem_pkg`: state enum (IDLE, WAIT, RESP); `LAT_W = 4` counter width; op encoding (OP_RD, OP_WR).
- Sub-module `dmem_ram`: single-port synchronous RAM, `DEPTH_WORDS` x 32, 4-bit byte-enable write, registered read.
- Top holds the FSM, latch registers, and the `cnt` down-counter.

## Test plan
- LATENCY=2. Store addr 0x40, data 0xDEADBEEF, mask 0xF, then load 0x40 -> busy high for 3 cycles each; load gives `o_rdata` = 0xDEADBEEF with a one-cycle `o_rvld` in RESP.
- Byte mask: store 0x11223344 to 0x80, then store 0x000000AA with mask 0x1 -> load returns 0x112233AA.
- Hold the request through RESP, then drop it -> exactly one access, and busy stays low in the following IDLE cycle.
- LATENCY=0, back-to-back loads from 0x0 and 0x4 -> busy 1 cycle each, RESP each, issue interval 2 cycles.
- DEPTH_WORDS=16: store to 0x44 (index 17) -> load from 0x04 returns that data. `i_ren & i_wen` together -> performed as a write, `o_err` pulses once.
- `i_rst_n` low during WAIT of a store to 0x10 -> busy drops next cycle, a later load of 0x10 returns the old value, `o_rdata` reads 0 after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

    localparam int unsigned LAT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    // Request payload captured at acceptance
    typedef struct packed {
        op_e               op;
        logic              err;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] mask;
    } req_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte-enable writes and a registered, resettable read port.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [MASK_W-1:0] i_be,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Contents are not reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < int'(MASK_W); b++) begin
                if (i_be[b]) begin
                    mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= mem[i_addr];
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// Fixed-latency data-memory responder: holds the pipeline via o_busy while an access is in flight.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ren,
    input  logic              i_wen,
    input  logic [31:0]       i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [MASK_W-1:0] i_mask,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvld,
    output logic              o_err
);

    localparam logic [LAT_W-1:0] CNT_INIT = (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             req_c;
    logic             busy_c;
    logic             complete_c;
    req_t             live_c, lat_q, cur_c;
    logic [AW-1:0]    lat_addr_q, cur_addr_c;
    logic             rvld_q, err_q;
    logic             unused_addr;

    assign req_c       = i_ren | i_wen;
    assign unused_addr = ^{i_addr[31:AW+2], i_addr[1:0]};

    // A simultaneous read and write is performed as a write and flagged
    always_comb begin
        live_c.op    = i_wen ? OP_WR : OP_RD;
        live_c.err   = i_ren & i_wen;
        live_c.wdata = i_wdata;
        live_c.mask  = i_mask;
    end

    // With zero latency the completing edge is the accepting edge, so use live inputs in IDLE
    assign cur_c      = (state_q == IDLE) ? live_c : lat_q;
    assign cur_addr_c = (state_q == IDLE) ? i_addr[AW+1:2] : lat_addr_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_c     = 1'b0;
        complete_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_c) begin
                    busy_c = 1'b1;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        complete_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                busy_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    complete_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_busy = i_rst_n & busy_c;

    always_ff @(posedge i_clk) begin
        if (state_q == IDLE && req_c) begin
            lat_q      <= live_c;
            lat_addr_q <= i_addr[AW+1:2];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rvld_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rvld_q <= complete_c & (cur_c.op == OP_RD);
            err_q  <= complete_c & cur_c.err;
        end
    end

    assign o_rvld = rvld_q;
    assign o_err  = err_q;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (complete_c & (cur_c.op == OP_WR) & i_rst_n),
        .i_be    (cur_c.mask),
        .i_re    (complete_c & (cur_c.op == OP_RD)),
        .i_addr  (cur_addr_c),
        .i_wdata (cur_c.wdata),
        .o_rdata (o_rdata)
    );

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: three instances (latency 2, latency 0, 16-word depth) share one stimulus bus.
module tb_dmem_resp;

    logic        clk;
    logic        rst_n;
    logic        ren, wen;
    logic [31:0] addr, wdata;
    logic [3:0]  mask;

    logic        busy_a, rvld_a, err_a;
    logic [31:0] rdata_a;
    logic        busy_b, rvld_b, err_b;
    logic [31:0] rdata_b;
    logic        busy_c, rvld_c, err_c;
    logic [31:0] rdata_c;

    logic [7:0]  busy_v, rvld_v, err_v;
    logic [31:0] rdata_l [8];

    int checks;
    int errors;

    dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ren(ren), .i_wen(wen), .i_addr(addr),
        .i_wdata(wdata), .i_mask(mask), .o_busy(busy_a), .o_rdata(rdata_a),
        .o_rvld(rvld_a), .o_err(err_a)
    );

    dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(0)) u_lat0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ren(ren), .i_wen(wen), .i_addr(addr),
        .i_wdata(wdata), .i_mask(mask), .o_busy(busy_b), .o_rdata(rdata_b),
        .o_rvld(rvld_b), .o_err(err_b)
    );

    dmem_resp #(.DEPTH_WORDS(16), .LATENCY(2)) u_d16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ren(ren), .i_wen(wen), .i_addr(addr),
        .i_wdata(wdata), .i_mask(mask), .o_busy(busy_c), .o_rdata(rdata_c),
        .o_rvld(rvld_c), .o_err(err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_logs();
        busy_v = '0;
        rvld_v = '0;
        err_v  = '0;
        for (int i = 0; i < 8; i++) rdata_l[i] = '0;
    endtask

    // Drive one cycle at the falling edge, then log the selected instance's outputs
    task automatic step(input int sel, input int idx, input logic rs, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        rst_n = rs; ren = r; wen = w; addr = a; wdata = d; mask = m;
        #1;
        case (sel)
            0: begin busy_v[idx] = busy_a; rvld_v[idx] = rvld_a; err_v[idx] = err_a; rdata_l[idx] = rdata_a; end
            1: begin busy_v[idx] = busy_b; rvld_v[idx] = rvld_b; err_v[idx] = err_b; rdata_l[idx] = rdata_b; end
            default: begin busy_v[idx] = busy_c; rvld_v[idx] = rvld_c; err_v[idx] = err_c; rdata_l[idx] = rdata_c; end
        endcase
    endtask

    // Hold a request for 'hold' cycles, then three idle cycles
    task automatic run_req(input int sel, input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m, input int hold);
        clear_logs();
        for (int i = 0; i < hold + 3; i++) begin
            if (i < hold) step(sel, i, 1'b1, r, w, a, d, m);
            else          step(sel, i, 1'b1, 1'b0, 1'b0, a, d, m);
        end
    endtask

    task automatic test_reset();
        clear_logs();
        step(0, 0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL reset_busy_lat2 got %b exp 0", busy_v[0]); end
        checks++; if (busy_b !== 1'b0 || busy_c !== 1'b0) begin errors++; $display("FAIL reset_busy_other got %b%b exp 00", busy_b, busy_c); end
        checks++; if (rdata_l[0] !== 32'h0 || rdata_b !== 32'h0 || rdata_c !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata_l[0]); end
        checks++; if (rvld_v[0] !== 1'b0 || err_v[0] !== 1'b0) begin errors++; $display("FAIL reset_pulses got rvld %b err %b exp 0 0", rvld_v[0], err_v[0]); end
        step(0, 1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (busy_v[1] !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy_v[1]); end
    endtask

    task automatic test_store_load();
        run_req(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 3);
        checks++; if (busy_v !== 8'h07) begin errors++; $display("FAIL store_busy got %b exp 00000111", busy_v); end
        checks++; if (rvld_v !== 8'h00) begin errors++; $display("FAIL store_rvld got %b exp 00000000", rvld_v); end
        run_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 3);
        checks++; if (busy_v !== 8'h07) begin errors++; $display("FAIL load_busy got %b exp 00000111", busy_v); end
        checks++; if (rvld_v !== 8'h08) begin errors++; $display("FAIL load_rvld got %b exp 00001000", rvld_v); end
        checks++; if (rdata_l[3] !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h exp deadbeef", rdata_l[3]); end
        run_req(0, 1'b0, 1'b1, 32'h100, 32'h12345678, 4'hF, 3);
        checks++; if (rdata_l[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold_on_store got %h exp deadbeef", rdata_l[5]); end
    endtask

    task automatic test_byte_mask();
        run_req(0, 1'b0, 1'b1, 32'h80, 32'h11223344, 4'hF, 3);
        run_req(0, 1'b0, 1'b1, 32'h80, 32'h000000AA, 4'h1, 3);
        run_req(0, 1'b0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'h0, 3);
        run_req(0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 3);
        checks++; if (rdata_l[3] !== 32'h112233AA) begin errors++; $display("FAIL byte_mask got %h exp 112233aa", rdata_l[3]); end
        run_req(0, 1'b0, 1'b1, 32'h80, 32'h99887766, 4'hC, 3);
        run_req(0, 1'b1, 1'b0, 32'h83, 32'h0, 4'h0, 3);
        checks++; if (rdata_l[3] !== 32'h998833AA) begin errors++; $display("FAIL upper_mask_unaligned got %h exp 998833aa", rdata_l[3]); end
    endtask

    task automatic test_hold_through_resp();
        run_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 4);
        checks++; if (busy_v !== 8'h07) begin errors++; $display("FAIL hold_busy got %b exp 00000111", busy_v); end
        checks++; if (rvld_v !== 8'h08) begin errors++; $display("FAIL hold_rvld got %b exp 00001000", rvld_v); end
    endtask

    task automatic test_back_to_back();
        run_req(1, 1'b0, 1'b1, 32'h0, 32'hA5A50000, 4'hF, 1);
        checks++; if (busy_v !== 8'h01) begin errors++; $display("FAIL lat0_store_busy got %b exp 00000001", busy_v); end
        run_req(1, 1'b0, 1'b1, 32'h4, 32'h00005A5A, 4'hF, 1);
        clear_logs();
        step(1, 0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        step(1, 1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        step(1, 2, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        step(1, 3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(1, 4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(1, 5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (busy_v !== 8'h05) begin errors++; $display("FAIL b2b_busy got %b exp 00000101", busy_v); end
        checks++; if (rvld_v !== 8'h0A) begin errors++; $display("FAIL b2b_rvld got %b exp 00001010", rvld_v); end
        checks++; if (rdata_l[1] !== 32'hA5A50000) begin errors++; $display("FAIL b2b_first got %h exp a5a50000", rdata_l[1]); end
        checks++; if (rdata_l[3] !== 32'h00005A5A) begin errors++; $display("FAIL b2b_second got %h exp 00005a5a", rdata_l[3]); end
    endtask

    task automatic test_wrap_and_err();
        run_req(2, 1'b0, 1'b1, 32'h44, 32'hC0FFEE01, 4'hF, 3);
        run_req(2, 1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 3);
        checks++; if (rdata_l[3] !== 32'hC0FFEE01) begin errors++; $display("FAIL wrap_rdata got %h exp c0ffee01", rdata_l[3]); end
        run_req(0, 1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 3);
        checks++; if (rdata_l[3] !== 32'h00005A5A) begin errors++; $display("FAIL nowrap_deep got %h exp 00005a5a", rdata_l[3]); end
        run_req(2, 1'b1, 1'b1, 32'h08, 32'h0BADF00D, 4'hF, 3);
        checks++; if (err_v !== 8'h08) begin errors++; $display("FAIL err_pulse got %b exp 00001000", err_v); end
        checks++; if (rvld_v !== 8'h00) begin errors++; $display("FAIL err_no_rvld got %b exp 00000000", rvld_v); end
        run_req(2, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 3);
        checks++; if (rdata_l[3] !== 32'h0BADF00D) begin errors++; $display("FAIL err_as_write got %h exp 0badf00d", rdata_l[3]); end
        checks++; if (err_v !== 8'h00) begin errors++; $display("FAIL err_quiet got %b exp 00000000", err_v); end
    endtask

    task automatic test_reset_mid();
        run_req(0, 1'b0, 1'b1, 32'h10, 32'h01010101, 4'hF, 3);
        run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 3);
        checks++; if (rdata_l[3] !== 32'h01010101) begin errors++; $display("FAIL pre_reset_load got %h exp 01010101", rdata_l[3]); end
        clear_logs();
        step(0, 0, 1'b1, 1'b0, 1'b1, 32'h10, 32'hFEEDFACE, 4'hF);
        step(0, 1, 1'b1, 1'b0, 1'b1, 32'h10, 32'hFEEDFACE, 4'hF);
        step(0, 2, 1'b0, 1'b0, 1'b1, 32'h10, 32'hFEEDFACE, 4'hF);
        step(0, 3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(0, 4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(0, 5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (busy_v !== 8'h03) begin errors++; $display("FAIL mid_reset_busy got %b exp 00000011", busy_v); end
        checks++; if (rvld_v !== 8'h00 || err_v !== 8'h00) begin errors++; $display("FAIL mid_reset_pulses got %b %b exp 0 0", rvld_v, err_v); end
        checks++; if (rdata_l[3] !== 32'h0 || rdata_l[5] !== 32'h0) begin errors++; $display("FAIL mid_reset_rdata got %h exp 00000000", rdata_l[3]); end
        run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 3);
        checks++; if (rdata_l[3] !== 32'h01010101) begin errors++; $display("FAIL store_dropped got %h exp 01010101", rdata_l[3]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; mask = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_store_load();
        test_byte_mask();
        test_hold_through_resp();
        test_back_to_back();
        test_wrap_and_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
